// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Central arbiter for the shared data bus. Each master presents a 2-bit
//   request code (00 idle, 01 low, 10 mid, 11 high). The arbiter grants the
//   bus to the highest code present, breaking ties round-robin. A grant is
//   held until the owner drops its request or MAX_TENURE cycles elapse. One
//   turnaround cycle with no owner always separates two grants.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   request    in   packed request codes, master k at bits [2k-1:2k-2]
//   grant      out  ID of current owner (1..N_MASTERS), 0 = bus free
//   bus_busy   out  high while grant != 0
//   owner_prio out  request code latched when the grant was issued
//   timeout    out  one-cycle pulse when a tenure is cut by MAX_TENURE
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int unsigned N_MASTERS  = 2,
    parameter int unsigned MAX_TENURE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2*N_MASTERS-1:0] request,
    output logic [2:0]             grant,
    output logic                   bus_busy,
    output logic [1:0]             owner_prio,
    output logic                   timeout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic [1:0] prio_q, prio_d;
    logic       timeout_q, timeout_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] ptr_q, ptr_d;

    // Request codes indexed by master ID; entry 0 and IDs above N_MASTERS stay 00.
    logic [1:0] codes [8];
    logic [1:0] best_code;
    logic [1:0] owner_code;
    logic [2:0] winner;
    logic       found;
    logic [3:0] cand;

    always_comb begin
        for (int unsigned k = 0; k < 8; k++) begin
            codes[k] = '0;
        end
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            codes[3'(k + 1)] = request[2*k +: 2];
        end
    end

    // Highest code present, then the first master holding it after the pointer.
    always_comb begin
        best_code = '0;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            if (codes[3'(k)] > best_code) begin
                best_code = codes[3'(k)];
            end
        end
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned off = 1; off <= N_MASTERS; off++) begin
            cand = {1'b0, ptr_q} + 4'(off);
            if (cand > 4'(N_MASTERS)) begin
                cand = cand - 4'(N_MASTERS);
            end
            if (!found && best_code != 2'b00 && codes[cand[2:0]] == best_code) begin
                winner = cand[2:0];
                found  = 1'b1;
            end
        end
    end

    assign owner_code = codes[grant_q];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        prio_d    = prio_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = winner;
                    prio_d  = best_code;
                    ptr_d   = winner;
                    cnt_d   = 4'd1;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // A voluntary drop wins over the tenure limit, so no timeout then.
                if (owner_code == 2'b00 || cnt_q >= 4'(MAX_TENURE)) begin
                    timeout_d = (owner_code != 2'b00);
                    grant_d   = '0;
                    prio_d    = '0;
                    cnt_d     = '0;
                    state_d   = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                prio_d  = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (grant_d != 3'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            prio_q    <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            ptr_q     <= 3'(N_MASTERS);
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            prio_q    <= prio_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    assign grant      = grant_q;
    assign bus_busy   = busy_q;
    assign owner_prio = prio_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//   Bench for bus_arbiter with N_MASTERS=3, MAX_TENURE=4. A reference model
//   tracks the bus owner, its tenure and the turnaround gap; a compare process
//   checks every output at each falling clock edge. Directed scenarios add
//   hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int NM = 3;
    localparam int MT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2*NM-1:0] request = '0;
    logic [2:0]    grant;
    logic          bus_busy;
    logic [1:0]    owner_prio;
    logic          timeout;

    int n_cmp = 0;
    int n_err = 0;

    bus_arbiter #(.N_MASTERS(NM), .MAX_TENURE(MT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .request    (request),
        .grant      (grant),
        .bus_busy   (bus_busy),
        .owner_prio (owner_prio),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_owner = 0;   // current owner ID, 0 = none
    int m_held  = 0;   // cycles the owner has held the bus
    int m_gap   = 0;   // idle cycles still to pass before arbitration
    int m_ptr   = NM;  // last winner
    int m_prio  = 0;
    int m_to    = 0;

    function automatic int mcode(input logic [2*NM-1:0] r, input int id);
        return int'((r >> (2*(id-1))) & 6'b11);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int best;
        int id;
        int c;
        if (!rst_n) begin
            m_owner = 0; m_held = 0; m_gap = 0; m_ptr = NM; m_prio = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_owner != 0) begin
                c = mcode(request, m_owner);
                if (c == 0 || m_held == MT) begin
                    m_to = (c != 0) ? 1 : 0;
                    m_owner = 0; m_prio = 0; m_held = 0; m_gap = 1;
                end else begin
                    m_held++;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else begin
                best = 0;
                for (int i = 1; i <= NM; i++)
                    if (mcode(request, i) > best) best = mcode(request, i);
                if (best > 0) begin
                    for (int s = NM; s >= 1; s--) begin
                        // scan descending so the earliest-after-pointer match wins last
                        id = ((m_ptr + s - 1) % NM) + 1;
                        if (mcode(request, id) == best) m_owner = id;
                    end
                    m_prio = best; m_held = 1; m_ptr = m_owner;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("grant",      int'(grant),      m_owner);
        chk("bus_busy",   int'(bus_busy),   (m_owner != 0) ? 1 : 0);
        chk("owner_prio", int'(owner_prio), m_prio);
        chk("timeout",    int'(timeout),    m_to);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with requests active
        rst_n = 1'b0; request = 6'b111111;
        cyc(3);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(bus_busy), 0);
        chk("rst_timeout", int'(timeout), 0);
        rst_n = 1'b1; request = 6'b000100;
        cyc(1);
        chk("first_grant", int'(grant), 2);
        chk("first_prio", int'(owner_prio), 1);
        request = '0;
        cyc(4);

        // short tenure
        request = 6'b000010;
        cyc(1); chk("short_g1", int'(grant), 1); chk("short_p", int'(owner_prio), 2);
        cyc(1); chk("short_g2", int'(grant), 1);
        request = '0;
        cyc(1); chk("short_rel", int'(grant), 0);
        cyc(3);

        // priority order 2 (11), then 3 (10), then 1 (01)
        request = 6'b101101;
        cyc(1); chk("prio_g2", int'(grant), 2); chk("prio_p3", int'(owner_prio), 3);
        request = 6'b100001;
        cyc(1); chk("prio_rel", int'(grant), 0);
        cyc(1); chk("prio_idle", int'(grant), 0);
        cyc(1); chk("prio_g3", int'(grant), 3); chk("prio_p2", int'(owner_prio), 2);
        request = 6'b000001;
        cyc(3); chk("prio_g1", int'(grant), 1);
        request = '0;
        cyc(4);

        // round robin with timeouts, pointer restored by reset
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        request = 6'b100010;
        cyc(1); chk("rr_g1a", int'(grant), 1);
        cyc(3); chk("rr_g1_last", int'(grant), 1);
        cyc(1); chk("rr_rel", int'(grant), 0); chk("rr_to", int'(timeout), 1);
        cyc(1); chk("rr_to_off", int'(timeout), 0);
        cyc(1); chk("rr_g3", int'(grant), 3);
        cyc(4); chk("rr_to2", int'(timeout), 1);
        cyc(2); chk("rr_g1b", int'(grant), 1);
        request = '0;
        cyc(4);

        // drop on the same cycle the tenure limit is hit: no timeout
        request = 6'b000100;
        cyc(1); chk("sim_g2", int'(grant), 2);
        cyc(3);
        request = '0;
        cyc(1); chk("sim_rel", int'(grant), 0); chk("sim_to", int'(timeout), 0);
        cyc(3);

        // no preemption
        request = 6'b000001;
        cyc(1); chk("np_g1", int'(grant), 1);
        request = 6'b110001;
        cyc(2); chk("np_hold", int'(grant), 1); chk("np_prio", int'(owner_prio), 1);
        cyc(2); chk("np_rel", int'(grant), 0); chk("np_to", int'(timeout), 1);
        cyc(2); chk("np_g3", int'(grant), 3); chk("np_p3", int'(owner_prio), 3);
        request = '0;
        cyc(6);

        // asynchronous reset mid-grant
        request = 6'b000100;
        cyc(1); chk("ar_g2", int'(grant), 2);
        #2 rst_n = 1'b0;
        #1 chk("ar_async", int'(grant), 0); chk("ar_busy", int'(bus_busy), 0);
        cyc(2);
        request = 6'b000101; rst_n = 1'b1;
        cyc(1); chk("ar_tie_g1", int'(grant), 1);
        request = '0;
        cyc(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central bus arbiter for the shared 5-bit data bus.
- Collects the 2-bit request code from every master and drives the common 3-bit grant bus that each master compares against its own ID.
- Master IDs run 1..N_MASTERS; grant value 0 means the bus is free.
- Arbitration is priority-first, with round-robin tie-break, a bounded tenure and a one-cycle turnaround between owners.

Parameters:
- N_MASTERS, 2, number of masters served (1..7); master k owns request bits [2k-1:2k-2].
- MAX_TENURE, 4, maximum consecutive cycles a single master may hold the grant (1..15).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- request  input  2*N_MASTERS  packed per-master request code: 00 idle, 01 low, 10 mid, 11 high priority.
- grant  output  3  ID of the current bus owner; 0 = no owner.
- bus_busy  output  1  high while grant != 0.
- owner_prio  output  2  priority code latched when the current grant was issued; 00 when idle.
- timeout  output  1  one-cycle pulse when a tenure is terminated by MAX_TENURE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - grant=0, bus_busy=0, owner_prio=00, timeout=0.
  - state=IDLE, tenure counter=0.
  - Round-robin pointer=N_MASTERS, so master 1 is checked first on ties.
- All outputs are registered.
- State IDLE:
  - Sample request each cycle. If all codes are 00, stay in IDLE with grant=0.
  - Otherwise select the highest code present. Among masters with that code, pick the first ID after the round-robin pointer, wrapping N_MASTERS->1.
  - On the next edge: grant=winner ID, owner_prio=winner code, pointer=winner, counter=1, go to GRANT.
  - Latency: request seen at edge k drives grant valid after edge k, with no extra cycle.
- State GRANT:
  - Owner request still non-zero and counter < MAX_TENURE: hold grant and increment counter.
  - Owner request 00: go to RELEASE on the next edge.
  - Counter == MAX_TENURE with owner request still non-zero: go to RELEASE and pulse timeout for exactly that one cycle.
  - No preemption: higher-priority requests from other masters, or a change in the owner's own code, are ignored until release.
- State RELEASE:
  - grant=0, bus_busy=0, owner_prio=00 for exactly one cycle (bus turnaround).
  - Then go to IDLE. A master that timed out competes again normally, and round-robin moves ties past it.
- Simultaneous events: owner drops its request on the same cycle the counter hits MAX_TENURE. This is treated as a normal release and timeout stays 0.
- Minimum gap between two different grants is 2 cycles: the RELEASE cycle plus the IDLE evaluation edge.
- Reset mid-grant forces grant=0 immediately, without waiting for a clock edge. Arbitration resumes from the reset pointer.
- Unused grant codes above N_MASTERS are never driven.
- The counter is 4 bits and never wraps, because it is bounded by MAX_TENURE.

Test Plan (N_MASTERS=3, MAX_TENURE=4):
- Reset: hold rst_n=0 with requests active -> grant=0, bus_busy=0, timeout=0. Release reset, set request for master 2 to 01 -> grant=2 one edge later, owner_prio=01.
- Short tenure: master 1 requests 10 for 2 cycles, then 00 -> grant=1 for 2 cycles, 0 for 1 RELEASE cycle, then idle.
- Priority: masters 1=01, 2=11, 3=10 requested together -> grant=2. Master 2 drops -> RELEASE, then grant=3. Master 3 drops -> RELEASE, then grant=1.
- Round-robin: masters 1 and 3 both hold 10 continuously -> grant sequence 1,0,3,0,1,0,3. Each tenure is 4 cycles with a timeout pulse at each release.
- No preemption: master 1 granted at 01. Master 3 raises 11 mid-tenure -> grant stays 1 until release or timeout, then grant=3.
- Async reset mid-grant: assert rst_n=0 between clock edges while grant=2 -> grant=0 before the next edge. After reset, with requests from masters 1 and 2 at equal code -> grant=1.
